// File: rtl/sonuc_bcd_cevirici.sv
// sonuc_bcd_cevirici
// Sequential binary-to-BCD converter placed after the calculator top level.
// It captures one 64-bit result with its valid/overflow flags and converts it
// to 20 packed BCD digits using a shift-and-add-3 (double-dabble) engine.
// One result is converted at a time. Completion is marked by a one-cycle
// pulse on bitti.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   basla          start request, sampled only while mesgul = 0
//   sonuc_in       64-bit result word
//   gecerli_in     result-valid flag, captured with basla
//   tasma_in       overflow flag, captured with basla
//   mesgul         busy, from the accepting edge until completion
//   bitti          done pulse, exactly one cycle
//   bcd            20 packed BCD digits, digit k at [4k+3:4k]
//   isaret         1 = negative value (only when SIGNED_IN = 1)
//   basamak_sayisi significant digit count, 1..20
//   hata           captured result was invalid or overflowed
//
// State | meaning
// BOS      | idle, waiting for basla
// DONUSTUR | 64 add-3/shift iterations
// BITIR    | publish the outputs, pulse bitti

module sonuc_bcd_cevirici #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        basla,
    input  logic [63:0] sonuc_in,
    input  logic        gecerli_in,
    input  logic        tasma_in,
    output logic        mesgul,
    output logic        bitti,
    output logic [79:0] bcd,
    output logic        isaret,
    output logic [4:0]  basamak_sayisi,
    output logic        hata
);

    typedef enum logic [1:0] {
        BOS      = 2'd0,
        DONUSTUR = 2'd1,
        BITIR    = 2'd2
    } durum_t;

    durum_t      state_q, state_d;
    logic [63:0] mag_q, mag_d;
    logic [79:0] scratch_q, scratch_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sign_q, sign_d;
    logic        err_q, err_d;
    logic        mesgul_q, mesgul_d;
    logic        bitti_q, bitti_d;
    logic [79:0] bcd_q, bcd_d;
    logic        isaret_q, isaret_d;
    logic [4:0]  basamak_q, basamak_d;
    logic        hata_q, hata_d;

    logic [79:0] adj;

    // Add 3 to every nibble that is 5 or more, so that the following left
    // shift carries into the next decimal digit instead of leaving 10..15.
    function automatic logic [79:0] add3(input logic [79:0] v);
        logic [79:0] r;
        r = v;
        for (int k = 0; k < 20; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Position of the highest nonzero digit plus one; an all-zero value still
    // shows a single digit.
    function automatic logic [4:0] digit_count(input logic [79:0] v);
        logic [4:0] n;
        n = 5'd1;
        for (int k = 0; k < 20; k++) begin
            if (v[4*k +: 4] != 4'd0) begin
                n = 5'(k + 1);
            end
        end
        return n;
    endfunction

    assign adj = add3(scratch_q);

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        err_d     = err_q;
        mesgul_d  = mesgul_q;
        bitti_d   = 1'b0;
        bcd_d     = bcd_q;
        isaret_d  = isaret_q;
        basamak_d = basamak_q;
        hata_d    = hata_q;

        case (state_q)
            BOS: begin
                if (basla) begin
                    mesgul_d  = 1'b1;
                    scratch_d = '0;
                    cnt_d     = 6'd63;
                    // Two's-complement negation in 64-bit unsigned arithmetic
                    // maps -2^63 onto 2^63, which still fits the magnitude.
                    if (SIGNED_IN && sonuc_in[63]) begin
                        mag_d  = ~sonuc_in + 64'd1;
                        sign_d = 1'b1;
                    end else begin
                        mag_d  = sonuc_in;
                        sign_d = 1'b0;
                    end
                    if (!gecerli_in || tasma_in) begin
                        err_d   = 1'b1;
                        state_d = BITIR;
                    end else begin
                        err_d   = 1'b0;
                        state_d = DONUSTUR;
                    end
                end
            end

            DONUSTUR: begin
                {scratch_d, mag_d} = {adj[78:0], mag_q, 1'b0};
                cnt_d              = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = BITIR;
                end
            end

            BITIR: begin
                bitti_d  = 1'b1;
                mesgul_d = 1'b0;
                hata_d   = err_q;
                state_d  = BOS;
                if (err_q) begin
                    bcd_d     = '0;
                    isaret_d  = 1'b0;
                    basamak_d = 5'd1;
                end else begin
                    bcd_d     = scratch_q;
                    isaret_d  = sign_q;
                    basamak_d = digit_count(scratch_q);
                end
            end

            default: begin
                state_d  = BOS;
                mesgul_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOS;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            mesgul_q  <= 1'b0;
            bitti_q   <= 1'b0;
            bcd_q     <= '0;
            isaret_q  <= 1'b0;
            basamak_q <= 5'd1;
            hata_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            mesgul_q  <= mesgul_d;
            bitti_q   <= bitti_d;
            bcd_q     <= bcd_d;
            isaret_q  <= isaret_d;
            basamak_q <= basamak_d;
            hata_q    <= hata_d;
        end
    end

    assign mesgul         = mesgul_q;
    assign bitti          = bitti_q;
    assign bcd            = bcd_q;
    assign isaret         = isaret_q;
    assign basamak_sayisi = basamak_q;
    assign hata           = hata_q;

endmodule

// File: tb/tb_sonuc_bcd_cevirici.sv
// Scoreboard bench for sonuc_bcd_cevirici. A signed and an unsigned instance
// share the same stimulus, and each expected entry carries the results for both.
module tb_sonuc_bcd_cevirici;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        basla = 1'b0;
    logic [63:0] sonuc_in = '0;
    logic        gecerli_in = 1'b0;
    logic        tasma_in = 1'b0;

    logic        mesgul, bitti, isaret, hata;
    logic [79:0] bcd;
    logic [4:0]  basamak_sayisi;
    logic        mesgul_u, bitti_u, isaret_u, hata_u;
    logic [79:0] bcd_u;
    logic [4:0]  basamak_sayisi_u;

    sonuc_bcd_cevirici #(.SIGNED_IN(1'b1)) dut (
        .clk(clk), .rst(rst), .basla(basla), .sonuc_in(sonuc_in),
        .gecerli_in(gecerli_in), .tasma_in(tasma_in),
        .mesgul(mesgul), .bitti(bitti), .bcd(bcd), .isaret(isaret),
        .basamak_sayisi(basamak_sayisi), .hata(hata)
    );

    sonuc_bcd_cevirici #(.SIGNED_IN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .basla(basla), .sonuc_in(sonuc_in),
        .gecerli_in(gecerli_in), .tasma_in(tasma_in),
        .mesgul(mesgul_u), .bitti(bitti_u), .bcd(bcd_u), .isaret(isaret_u),
        .basamak_sayisi(basamak_sayisi_u), .hata(hata_u)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [79:0] bcd_s;
        logic        isa_s;
        logic [4:0]  n_s;
        logic [79:0] bcd_u;
        logic [4:0]  n_u;
        logic        hata;
        int unsigned acc;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    // Held output values {bcd, isaret, basamak_sayisi, hata} per instance.
    logic [86:0] hold_s = {80'd0, 1'b0, 5'd1, 1'b0};
    logic [86:0] hold_u = {80'd0, 1'b0, 5'd1, 1'b0};

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic void to_bcd(input logic [63:0] m, output logic [79:0] b,
                                   output logic [4:0] n);
        logic [63:0] r;
        r = m;
        b = '0;
        n = 5'd1;
        for (int i = 0; i < 20; i++) begin
            b[4*i +: 4] = 4'(r % 64'd10);
            r = r / 64'd10;
            if (b[4*i +: 4] != 4'd0) n = 5'(i + 1);
        end
    endfunction

    function automatic exp_t make_exp(input logic [63:0] v, input logic g,
                                      input logic t, input int unsigned acc);
        exp_t e;
        logic [63:0] mag;
        e.acc = acc;
        if (!g || t) begin
            e.bcd_s = '0; e.isa_s = 1'b0; e.n_s = 5'd1;
            e.bcd_u = '0; e.n_u = 5'd1; e.hata = 1'b1;
        end else begin
            e.hata  = 1'b0;
            e.isa_s = v[63];
            mag     = v[63] ? (64'd0 - v) : v;
            to_bcd(mag, e.bcd_s, e.n_s);
            to_bcd(v, e.bcd_u, e.n_u);
        end
        return e;
    endfunction

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (mesgul && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("idle_timeout", 96'(mesgul), 96'd0);
    endtask

    task automatic send(input logic [63:0] v, input logic g, input logic t);
        wait_idle();
        sonuc_in   = v;
        gecerli_in = g;
        tasma_in   = t;
        basla      = 1'b1;
        q.push_back(make_exp(v, g, t, cyc + 1));
        @(negedge clk);
        basla = 1'b0;
        check("mesgul_after_accept", 96'(mesgul), 96'd1);
    endtask

    // Monitor: pops and compares on every bitti, checks holding otherwise.
    logic prev_bitti = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_bitti = 1'b0;
            end else if (bitti) begin
                check("bitti_single", 96'(prev_bitti), 96'd0);
                check("bitti_u", 96'(bitti_u), 96'd1);
                check("mesgul_in_bitti", 96'(mesgul), 96'd0);
                if (q.size() == 0) begin
                    check("unexpected_bitti", 96'(q.size()), 96'd1);
                end else begin
                    e = q.pop_front();
                    check("latency", 96'(cyc), 96'(e.acc + (e.hata ? 1 : 65)));
                    check("bcd_s", 96'(bcd), 96'(e.bcd_s));
                    check("isaret_s", 96'(isaret), 96'(e.isa_s));
                    check("basamak_s", 96'(basamak_sayisi), 96'(e.n_s));
                    check("hata_s", 96'(hata), 96'(e.hata));
                    check("bcd_u", 96'(bcd_u), 96'(e.bcd_u));
                    check("isaret_u", 96'(isaret_u), 96'd0);
                    check("basamak_u", 96'(basamak_sayisi_u), 96'(e.n_u));
                    check("hata_u", 96'(hata_u), 96'(e.hata));
                    hold_s = {e.bcd_s, e.isa_s, e.n_s, e.hata};
                    hold_u = {e.bcd_u, 1'b0, e.n_u, e.hata};
                end
                prev_bitti = 1'b1;
            end else begin
                check("hold_s", 96'({bcd, isaret, basamak_sayisi, hata}), 96'(hold_s));
                check("hold_u", 96'({bcd_u, isaret_u, basamak_sayisi_u, hata_u}), 96'(hold_u));
                check("bitti_u_low", 96'(bitti_u), 96'd0);
                prev_bitti = 1'b0;
            end
        end
    end

    initial begin
        logic [63:0] v;
        int          r;
        int          w;

        repeat (3) @(negedge clk);
        check("reset_outs", 96'({mesgul, bitti, bcd, isaret, basamak_sayisi, hata}),
              96'({1'b0, 1'b0, 80'd0, 1'b0, 5'd1, 1'b0}));
        check("reset_outs_u", 96'({mesgul_u, bitti_u, bcd_u, isaret_u, basamak_sayisi_u, hata_u}),
              96'({1'b0, 1'b0, 80'd0, 1'b0, 5'd1, 1'b0}));
        rst = 1'b0;

        // Directed cases.
        send(64'd0, 1'b1, 1'b0);
        send(64'd12345, 1'b1, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send(64'h8000_0000_0000_0000, 1'b1, 1'b0);
        send(64'd777, 1'b0, 1'b0);
        send(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
        send(64'd99999, 1'b1, 1'b0);

        // basla held high with sonuc_in changing every cycle: only the values
        // present at edges 0, 66 and 132 are converted.
        wait_idle();
        basla      = 1'b1;
        gecerli_in = 1'b1;
        tasma_in   = 1'b0;
        for (int t = 0; t <= 132; t++) begin
            sonuc_in = {$urandom, $urandom};
            if (t % 66 == 0) q.push_back(make_exp(sonuc_in, 1'b1, 1'b0, cyc + 1));
            @(negedge clk);
        end
        basla = 1'b0;

        // Reset 30 clocks into a conversion.
        send(64'd555555, 1'b1, 1'b0);
        repeat (29) @(negedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        hold_s = {80'd0, 1'b0, 5'd1, 1'b0};
        hold_u = {80'd0, 1'b0, 5'd1, 1'b0};
        #1;
        check("mid_reset", 96'({mesgul, bitti, bcd, isaret, basamak_sayisi, hata}),
              96'({1'b0, 1'b0, 80'd0, 1'b0, 5'd1, 1'b0}));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(64'd987654321, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       v = {$urandom, $urandom};
            else if (r < 6)  v = 64'($urandom_range(0, 999));
            else if (r < 8)  v = 64'd0 - 64'($urandom_range(1, 999));
            else             v = {32'd0, $urandom};
            send(v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
        end

        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", 96'(q.size()), 96'd0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
